// File: rtl/mem_stream_reader_if.sv
// mem_stream_reader_if: control, RAM read port and output stream bundle; abort exists only with MEM_READER_ABORT_EN
interface mem_stream_reader_if #(
  parameter int WIDTH = 8,
  parameter int ADDR_SIZE = 10
);
  logic                 start;
  logic [ADDR_SIZE-1:0] start_addr;
  logic [ADDR_SIZE:0]   length;
  logic                 busy;
  logic                 done;
  logic [ADDR_SIZE-1:0] mem_ra;
  logic [WIDTH-1:0]     mem_rdata;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
`ifdef MEM_READER_ABORT_EN
  logic                 abort;
`endif
  modport master (
    output start, start_addr, length, mem_rdata, out_ready,
`ifdef MEM_READER_ABORT_EN
    output abort,
`endif
    input  busy, done, mem_ra, out_data, out_valid
  );
  modport slave (
    input  start, start_addr, length, mem_rdata, out_ready,
`ifdef MEM_READER_ABORT_EN
    input  abort,
`endif
    output busy, done, mem_ra, out_data, out_valid
  );
endinterface

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: streams length words from a sync-read RAM; abort port added by MEM_READER_ABORT_EN
module mem_stream_reader #(
  parameter int WIDTH = 8,
  parameter int ADDR_SIZE = 10
) (
  input logic                clk,
  input logic                reset_n,
  mem_stream_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d, ra_q, ra_d;
  logic [ADDR_SIZE:0]   remain_q, remain_d;
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [1:0]           wp_q, wp_d, rp_q, rp_d, cnt_q, cnt_d;
  logic [WIDTH-1:0]     buf_q [4];
  logic [WIDTH-1:0]     buf_d [4];
  logic                 pop, issue, kill;
  logic [2:0]           occ;
  // v1: address on mem_ra this cycle, v2: its data on mem_rdata; both count against the 3-word buffer
  always_comb begin
    pop = (cnt_q != 2'd0) && bus.out_ready;
    occ = 3'(v1_q) + 3'(v2_q) + 3'(cnt_q) - 3'(pop);
`ifdef MEM_READER_ABORT_EN
    kill = bus.abort && (state_q != IDLE);
`else
    kill = 1'b0;
`endif
    issue = (state_q == RUN) && !kill && (occ < 3'd3);
    state_d = state_q;
    addr_d = addr_q;
    ra_d = ra_q;
    remain_d = remain_q;
    busy_d = busy_q;
    done_d = 1'b0;
    v1_d = issue;
    v2_d = v1_q;
    buf_d = buf_q;
    if (v2_q) buf_d[wp_q] = bus.mem_rdata;
    wp_d = wp_q + 2'(v2_q);
    rp_d = rp_q + 2'(pop);
    cnt_d = cnt_q + 2'(v2_q) - 2'(pop);
    if (state_q == IDLE && bus.start) begin
      if (bus.length == '0) done_d = 1'b1;
      else begin
        ra_d = bus.start_addr;
        addr_d = bus.start_addr + ADDR_SIZE'(1);
        remain_d = bus.length - (ADDR_SIZE+1)'(1);
        v1_d = 1'b1;
        busy_d = 1'b1;
        state_d = (bus.length == (ADDR_SIZE+1)'(1)) ? DRAIN : RUN;
      end
    end
    if (issue) begin
      ra_d = addr_q;
      addr_d = addr_q + ADDR_SIZE'(1);
      remain_d = remain_q - (ADDR_SIZE+1)'(1);
      state_d = (remain_q == (ADDR_SIZE+1)'(1)) ? DRAIN : RUN;
    end
    if (state_q == DRAIN && pop && !v1_q && !v2_q && cnt_q == 2'd1) begin
      state_d = IDLE;
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (kill) begin
      state_d = IDLE;
      v1_d = 1'b0;
      v2_d = 1'b0;
      wp_d = 2'd0;
      rp_d = 2'd0;
      cnt_d = 2'd0;
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      ra_q <= '0;
      remain_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wp_q <= 2'd0;
      rp_q <= 2'd0;
      cnt_q <= 2'd0;
      buf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      ra_q <= ra_d;
      remain_q <= remain_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      busy_q <= busy_d;
      done_q <= done_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end
  assign bus.mem_ra = ra_q;
  assign bus.out_data = buf_q[rp_q];
  assign bus.out_valid = cnt_q != 2'd0;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: directed checks of mem_stream_reader against a RAM holding RAM[i]=i[7:0]
module tb_mem_stream_reader;
  logic clk = 1'b0;
  logic reset_n;
  int errors = 0;
  int checks = 0;
  logic [7:0] mem [1024];
  always #5 clk = ~clk;
  mem_stream_reader_if #(.WIDTH(8), .ADDR_SIZE(10)) bus ();
  mem_stream_reader #(.WIDTH(8), .ADDR_SIZE(10)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_ra];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic basic(input logic [9:0] base, input string tag);
    logic [9:0] a;
    bus.start = 1'b1; bus.start_addr = base; bus.length = 11'd4; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    chk({tag, " ra"}, 32'(bus.mem_ra), 32'(base));
    chk({tag, " valid e1"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, " valid e2"}, 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a = base + 10'(k);
      chk({tag, " valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, " data"}, 32'(bus.out_data), 32'(a[7:0]));
      chk({tag, " done early"}, 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    chk({tag, " valid end"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " done"}, 32'(bus.done), 32'd1);
    chk({tag, " busy end"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic collect(input logic [9:0] base, input bit stall, input int want,
                         input int poke_at, input string tag);
    logic [9:0] a;
    logic [7:0] held;
    bit prev;
    int t;
    int got;
    held = 8'd0; prev = 1'b0; t = 0; got = 0;
    while (got < want && t < 300) begin
      @(negedge clk);
      t++;
      bus.start = (t == poke_at);
      if (t == poke_at) begin
        bus.start_addr = 10'h200;
        bus.length = 11'd5;
      end
      if (stall) bus.out_ready = (t % 3 == 1);
      if (prev) begin
        chk({tag, " hold valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, " hold data"}, 32'(bus.out_data), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        a = base + 10'(got);
        chk({tag, " data"}, 32'(bus.out_data), 32'(a[7:0]));
        got++;
      end
      prev = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
    end
    chk({tag, " count"}, 32'(got), 32'(want));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    reset_n = 1'b0;
    bus.start = 1'b0; bus.start_addr = '0; bus.length = '0; bus.out_ready = 1'b0;
`ifdef MEM_READER_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst valid", 32'(bus.out_valid), 32'd0);
    chk("rst data", 32'(bus.out_data), 32'd0);
    chk("rst ra", 32'(bus.mem_ra), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    basic(10'h010, "basic");
    @(negedge clk);
    chk("basic done drop", 32'(bus.done), 32'd0);
    basic(10'h3FE, "wrap");
    chk("wrap ra hold", 32'(bus.mem_ra), 32'h001);
    // next transfer is started in the done cycle of the previous one
    bus.start = 1'b1; bus.start_addr = 10'h020; bus.length = 11'd8;
    collect(10'h020, 1'b1, 8, 0, "stall");
    @(negedge clk);
    chk("stall done", 32'(bus.done), 32'd1);
    chk("stall busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("stall done drop", 32'(bus.done), 32'd0);
    bus.out_ready = 1'b1;
    bus.start = 1'b1; bus.start_addr = 10'h100; bus.length = 11'd16;
    collect(10'h100, 1'b0, 16, 3, "busy start");
    @(negedge clk);
    chk("busy start done", 32'(bus.done), 32'd1);
    chk("busy start ra", 32'(bus.mem_ra), 32'h10F);
    repeat (3) begin
      @(negedge clk);
      chk("busy start idle valid", 32'(bus.out_valid), 32'd0);
      chk("busy start idle busy", 32'(bus.busy), 32'd0);
      chk("busy start idle done", 32'(bus.done), 32'd0);
    end
    bus.start = 1'b1; bus.start_addr = 10'h300; bus.length = 11'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("len0 done", 32'(bus.done), 32'd1);
    chk("len0 busy", 32'(bus.busy), 32'd0);
    chk("len0 valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("len0 done drop", 32'(bus.done), 32'd0);
    chk("len0 busy after", 32'(bus.busy), 32'd0);
    chk("len0 valid after", 32'(bus.out_valid), 32'd0);
`ifdef MEM_READER_ABORT_EN
    bus.start = 1'b1; bus.start_addr = 10'h080; bus.length = 11'd8;
    collect(10'h080, 1'b0, 2, 0, "abort");
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort valid", 32'(bus.out_valid), 32'd0);
    chk("abort done", 32'(bus.done), 32'd1);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort ra", 32'(bus.mem_ra), 32'h084);
    repeat (3) begin
      @(negedge clk);
      chk("abort idle done", 32'(bus.done), 32'd0);
      chk("abort idle valid", 32'(bus.out_valid), 32'd0);
      chk("abort no reads", 32'(bus.mem_ra), 32'h084);
    end
`endif
    bus.start = 1'b1; bus.start_addr = 10'h040; bus.length = 11'd8;
    collect(10'h040, 1'b0, 3, 0, "reset");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid rst valid", 32'(bus.out_valid), 32'd0);
    chk("mid rst data", 32'(bus.out_data), 32'd0);
    chk("mid rst ra", 32'(bus.mem_ra), 32'd0);
    chk("mid rst busy", 32'(bus.busy), 32'd0);
    chk("mid rst done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post rst done", 32'(bus.done), 32'd0);
      chk("post rst busy", 32'(bus.busy), 32'd0);
      chk("post rst valid", 32'(bus.out_valid), 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 Parameter WIDTH, default 8: memory cell and stream data width in bits.
REQ-002 Parameter ADDR_SIZE, default 10: memory address width; depth = 2^ADDR_SIZE.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin transfer; sampled only in IDLE.
REQ-006 start_addr  input  ADDR_SIZE  first word address; sampled with start.
REQ-007 length  input  ADDR_SIZE+1  word count, 0..2^ADDR_SIZE; sampled with start.
REQ-008 mem_ra  output  ADDR_SIZE  read address to the synchronous-read RAM.
REQ-009 mem_rdata  input  WIDTH  RAM read data; valid one clock edge after mem_ra is sampled.
REQ-010 out_data  output  WIDTH  stream data.
REQ-011 out_valid  output  1  out_data holds a word.
REQ-012 out_ready  input  1  consumer accepts; a word transfers on an edge with out_valid && out_ready.
REQ-013 busy  output  1  high from the edge after start until done.
REQ-014 done  output  1  one-cycle pulse at transfer end.
REQ-015 abort  input  1  terminate transfer (present only with MEM_READER_ABORT_EN).

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN; IDLE->RUN on start with length>0; RUN->DRAIN after the last read is issued; DRAIN->IDLE on the edge the last word transfers.
REQ-017 start with length=0 SHALL leave busy low, emit no words, and pulse done on the following cycle.
REQ-018 start asserted while busy SHALL be ignored and SHALL NOT alter start_addr, length or the stream.
REQ-019 Words SHALL be emitted in order from addresses start_addr, start_addr+1, ..., start_addr+length-1, address arithmetic modulo 2^ADDR_SIZE (wraps past top to 0).
REQ-020 With out_ready held high, the first out_valid SHALL rise at the 2nd rising edge after the edge sampling start, and subsequent words SHALL follow one per cycle.
REQ-021 While out_valid && !out_ready, out_data and out_valid SHALL remain stable.
REQ-022 Reads SHALL be issued only when storage for the returning word is guaranteed (in-flight plus buffered <= 2); no word SHALL be lost or duplicated under any out_ready pattern.
REQ-023 Exactly length words SHALL be transferred per transfer; out_valid SHALL be low in IDLE.
REQ-024 done SHALL pulse for exactly one cycle, the cycle after the last word transfers; busy SHALL fall together with done rising.
REQ-025 A new start SHALL be accepted in the cycle done is high.
REQ-026 mem_ra SHALL hold its last value when no read is issued.

Reset
REQ-027 On reset_n low, SHALL asynchronously force IDLE, busy=0, done=0, out_valid=0, out_data=0, mem_ra=0, clearing buffered and in-flight words.
REQ-028 Reset mid-transfer SHALL discard the transfer; no done pulse SHALL follow reset release.

Configuration
REQ-029 Macro MEM_READER_ABORT_EN SHALL, when defined, add port abort: abort high in RUN or DRAIN SHALL stop issuing reads, drop buffered words, force out_valid low on the next edge, and pulse done the cycle after; abort in IDLE SHALL be ignored.
REQ-030 Without MEM_READER_ABORT_EN the abort port SHALL be absent and transfers SHALL always run to length words.

Verification
REQ-031 start_addr=0x010, length=4, out_ready=1, RAM[i]=i -> out_data 0x10,0x11,0x12,0x13 on consecutive cycles, first valid 2 edges after start, done 1 cycle after last.
REQ-032 start_addr=0x3FE, length=4 -> words from 0x3FE,0x3FF,0x000,0x001.
REQ-033 length=8, out_ready toggling 1,0,0,1,... -> 8 words in order, out_data stable during stalls, no loss/duplication.
REQ-034 length=0 -> no out_valid, busy stays 0, done pulses once; second start during busy of a length=16 transfer -> ignored, 16 words only.
REQ-035 reset_n low after 3 of 8 words -> all outputs 0 immediately, no done after release; with MEM_READER_ABORT_EN, abort after 2 words -> out_valid low next edge, done pulse, no further reads.
